// File: rtl/multi_timer.sv
// Multi-channel programmable interval timer with a word-addressed register file.
// Each channel has a prescaler, a down-counter, three run modes and a sticky W1C pending flag.
module multi_timer #(
    parameter  int CH      = 2,
    parameter  int WIDTH   = 32,
    parameter  int PRESC_W = 16,
    localparam int AW      = $clog2(CH) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [31:0]   din,
    output logic [31:0]   dout,
    output logic [CH-1:0] irq_vec,
    output logic          irq,
    output logic [CH-1:0] tmr_out
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CNT  = 1'b1
    } state_e;

    localparam logic [3:0] CH_LIM      = 4'(CH);
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PRESET  = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_SQUARE = 2'b10;

    state_e             state_q  [CH];
    state_e             state_d  [CH];
    logic [1:0]         mode_q   [CH];
    logic [1:0]         mode_d   [CH];
    logic [PRESC_W-1:0] presc_q  [CH];
    logic [PRESC_W-1:0] presc_d  [CH];
    logic [PRESC_W-1:0] pc_q     [CH];
    logic [PRESC_W-1:0] pc_d     [CH];
    logic [WIDTH-1:0]   preset_q [CH];
    logic [WIDTH-1:0]   preset_d [CH];
    logic [WIDTH-1:0]   count_q  [CH];
    logic [WIDTH-1:0]   count_d  [CH];
    logic [CH-1:0]      en_q, en_d;
    logic [CH-1:0]      im_q, im_d;
    logic [CH-1:0]      ip_q, ip_d;
    logic [CH-1:0]      tmr_q, tmr_d;

    logic [3:0]         ch_sel_s;
    logic [1:0]         reg_sel_s;
    logic               ch_ok_s;
    logic [CH-1:0]      sel_s;
    logic [CH-1:0]      wr_s;
    logic [CH-1:0]      expire_s;
    logic [31:0]        rd_word_s [CH];
    logic               unused_din_s;

    // With a single channel there is no channel field in the address.
    generate
        if (AW > 2) begin : g_ch_field
            assign ch_sel_s = 4'(addr[AW-1:2]);
        end else begin : g_no_ch_field
            assign ch_sel_s = 4'd0;
        end
    endgenerate

    assign reg_sel_s    = addr[1:0];
    assign ch_ok_s      = (ch_sel_s < CH_LIM);
    assign unused_din_s = ^din;

    // Per-channel address decode for reads and write strobes.
    always_comb begin
        sel_s = '0;
        wr_s  = '0;
        for (int c = 0; c < CH; c++) begin
            sel_s[c] = ch_ok_s && (ch_sel_s == 4'(c));
            wr_s[c]  = we && sel_s[c];
        end
    end

    // Channel FSMs: count/expiry first, then bus writes override where they collide.
    always_comb begin
        en_d     = en_q;
        im_d     = im_q;
        ip_d     = ip_q;
        tmr_d    = tmr_q;
        expire_s = '0;
        for (int c = 0; c < CH; c++) begin
            state_d[c]  = state_q[c];
            mode_d[c]   = mode_q[c];
            presc_d[c]  = presc_q[c];
            pc_d[c]     = pc_q[c];
            preset_d[c] = preset_q[c];
            count_d[c]  = count_q[c];

            case (state_q[c])
                ST_IDLE: begin
                    if (en_q[c]) begin
                        state_d[c] = ST_CNT;
                        count_d[c] = preset_q[c];
                        pc_d[c]    = '0;
                    end else begin
                        state_d[c] = ST_IDLE;
                    end
                end
                ST_CNT: begin
                    if (!en_q[c]) begin
                        state_d[c] = ST_IDLE;
                    end else if (pc_q[c] == presc_q[c]) begin
                        pc_d[c] = '0;
                        if (count_q[c] != '0) begin
                            count_d[c] = count_q[c] - WIDTH'(1);
                        end else begin
                            expire_s[c] = 1'b1;
                            ip_d[c]     = 1'b1;
                            if ((mode_q[c] == MODE_AUTO) || (mode_q[c] == MODE_SQUARE)) begin
                                count_d[c] = preset_q[c];
                                tmr_d[c]   = (mode_q[c] == MODE_SQUARE) ? ~tmr_q[c] : tmr_q[c];
                            end else begin
                                en_d[c]    = 1'b0;
                                state_d[c] = ST_IDLE;
                            end
                        end
                    end else begin
                        pc_d[c] = pc_q[c] + PRESC_W'(1);
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase

            // An expiry in the same cycle keeps IP set even against a W1C.
            case ({wr_s[c], reg_sel_s})
                {1'b1, REG_CTRL}: begin
                    en_d[c]    = din[0];
                    mode_d[c]  = din[2:1];
                    im_d[c]    = din[3];
                    presc_d[c] = din[16 +: PRESC_W];
                end
                {1'b1, REG_PRESET}: preset_d[c] = din[WIDTH-1:0];
                {1'b1, REG_COUNT}:  count_d[c]  = din[WIDTH-1:0];
                {1'b1, REG_STATUS}: ip_d[c]     = expire_s[c] | (ip_q[c] & ~din[0]);
                default: ;
            endcase
        end
    end

    // State registers for every channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q  <= '0;
            im_q  <= '0;
            ip_q  <= '0;
            tmr_q <= '0;
            for (int c = 0; c < CH; c++) begin
                state_q[c]  <= ST_IDLE;
                mode_q[c]   <= 2'b00;
                presc_q[c]  <= '0;
                pc_q[c]     <= '0;
                preset_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            en_q  <= en_d;
            im_q  <= im_d;
            ip_q  <= ip_d;
            tmr_q <= tmr_d;
            for (int c = 0; c < CH; c++) begin
                state_q[c]  <= state_d[c];
                mode_q[c]   <= mode_d[c];
                presc_q[c]  <= presc_d[c];
                pc_q[c]     <= pc_d[c];
                preset_q[c] <= preset_d[c];
                count_q[c]  <= count_d[c];
            end
        end
    end

    // Readable image of each channel's register selected by addr[1:0].
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            rd_word_s[c] = 32'd0;
            case (reg_sel_s)
                REG_CTRL: begin
                    rd_word_s[c][16 +: PRESC_W] = presc_q[c];
                    rd_word_s[c][3]             = im_q[c];
                    rd_word_s[c][2:1]           = mode_q[c];
                    rd_word_s[c][0]             = en_q[c];
                end
                REG_PRESET: rd_word_s[c][WIDTH-1:0] = preset_q[c];
                REG_COUNT:  rd_word_s[c][WIDTH-1:0] = count_q[c];
                REG_STATUS: rd_word_s[c][0]         = ip_q[c];
                default:    rd_word_s[c]            = 32'd0;
            endcase
        end
    end

    // Out-of-range channels select nothing and therefore read as zero.
    always_comb begin
        dout = 32'd0;
        for (int c = 0; c < CH; c++) begin
            dout = dout | (sel_s[c] ? rd_word_s[c] : 32'd0);
        end
    end

    assign irq_vec = ip_q & im_q;
    assign irq     = |irq_vec;
    assign tmr_out = tmr_q;
endmodule
